// File: rtl/ram_stream_reader.sv
// ram_stream_reader: drains a block of a 1-cycle-latency RAM into a valid/ready stream with last marker
module ram_stream_reader #(
    parameter int AW = 8,
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic [AW-1:0] base_addr,
    input  logic [AW:0]   len,
    output logic          busy,
    output logic          done,
    output logic          rd_en,
    output logic [AW-1:0] rd_addr,
    input  logic [DW-1:0] rd_data,
    output logic [DW-1:0] out_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic          out_last
);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    state_t state, state_n;
    logic [AW-1:0] base_q;
    logic [AW:0] len_q, issued, issued_inc;
    logic rd_last, cap, cap_last, pop, accept, issue;
    logic [2:0] v, v_n, l, l_n, sv, sl, credit;
    logic [1:0] sel;
    logic [DW-1:0] q [3];
    logic [DW-1:0] q_n [3];
    logic [DW-1:0] sq [3];
    assign out_valid = v[0];
    assign out_last = l[0];
    assign out_data = q[0];
    assign pop = v[0] & out_ready;
    assign accept = state == IDLE && start;
    assign issued_inc = issued + (AW+1)'(1);
    assign credit = 3'(v[0]) + 3'(v[1]) + 3'(v[2]) + 3'(rd_en) + 3'(cap) - 3'(pop);
    assign issue = state == RUN && issued < len_q && credit < 3'd3;
    always_comb begin
        state_n = state;
        state_n = accept ? (len == '0 ? DONE : RUN) :
                  (state == RUN && pop && l[0]) ? DONE :
                  (state == DONE) ? IDLE : state;
    end
    always_comb begin
        sv = pop ? {1'b0, v[2:1]} : v;
        sl = pop ? {1'b0, l[2:1]} : l;
        sq[0] = pop ? q[1] : q[0];
        sq[1] = pop ? q[2] : q[1];
        sq[2] = pop ? '0 : q[2];
        sel = !sv[0] ? 2'd0 : !sv[1] ? 2'd1 : 2'd2;
        v_n = sv;
        l_n = sl;
        q_n = sq;
        if (cap) begin
            v_n[sel] = 1'b1;
            l_n[sel] = cap_last;
            q_n[sel] = rd_data;
        end
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            busy <= 1'b0;
            done <= 1'b0;
            base_q <= '0;
            len_q <= '0;
            issued <= '0;
            rd_en <= 1'b0;
            rd_addr <= '0;
            rd_last <= 1'b0;
            cap <= 1'b0;
            cap_last <= 1'b0;
            v <= '0;
            l <= '0;
            q <= '{default: '0};
        end else begin
            state <= state_n;
            busy <= state_n == RUN;
            done <= state_n == DONE;
            rd_en <= issue || (accept && len != '0);
            cap <= rd_en;
            cap_last <= rd_en & rd_last;
            v <= v_n;
            l <= l_n;
            q <= q_n;
            if (accept) begin
                base_q <= base_addr;
                len_q <= len;
                issued <= (AW+1)'(len != '0);
                rd_addr <= base_addr;
                rd_last <= len == (AW+1)'(1);
            end else if (issue) begin
                rd_addr <= base_q + issued[AW-1:0];
                issued <= issued_inc;
                rd_last <= issued_inc == len_q;
            end
        end
    end
endmodule

// File: tb/tb_ram_stream_reader.sv
// tb_ram_stream_reader: directed bench with queue scoreboard and a negedge monitor
module tb_ram_stream_reader;
    logic clk = 0, rst_n = 0, start = 0, out_ready = 1;
    logic busy, done, rd_en, out_valid, out_last;
    logic [7:0] base_addr = 0, rd_addr;
    logic [8:0] len = 0;
    logic [31:0] rd_data = 0, out_data;
    logic [31:0] mem [256];
    int applied = 0, miscompares = 0, words = 0, done_cnt = 0, outst = 0, rdy_mode = 0, pi = 0;
    int w0, d0;
    logic pend_pop = 0, stall = 0, exp_done_next = 0, hs;
    logic [31:0] stall_data = 0;
    logic [32:0] mon_e;
    logic [32:0] exp_q [$];
    logic [7:0] addr_q [$];
    logic [5:0] pat = 6'b100101;

    ram_stream_reader #(.AW(8), .DW(32)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr), .len(len),
        .busy(busy), .done(done), .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready), .out_last(out_last)
    );

    always #5 clk = ~clk;

    initial for (int i = 0; i < 256; i++) mem[i] = 32'hA0 + i;

    always @(posedge clk) if (rd_en) rd_data <= mem[rd_addr];

    always @(posedge clk) begin
        #2;
        out_ready = rdy_mode == 0 ? 1'b1 : rdy_mode == 1 ? pat[5-pi] : 1'b0;
        if (rdy_mode == 1) pi = (pi + 1) % 6;
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        applied++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic fail(input string name);
        applied++;
        miscompares++;
        $display("FAIL %s: unexpected event at %0t", name, $time);
    endtask

    always @(negedge clk) begin
        if (!rst_n) begin
            outst = 0;
            pend_pop = 0;
            stall = 0;
            exp_done_next = 0;
        end else begin
            if (exp_done_next) begin
                chk("done_after_last", {done, busy}, 2'b10);
                exp_done_next = 0;
            end
            if (done) done_cnt++;
            if (stall) begin
                chk("stall_valid", out_valid, 1);
                chk("stall_data", out_data, stall_data);
            end
            outst = outst + int'(rd_en) - int'(pend_pop);
            if (rd_en) begin
                chk("outstanding_le3", outst <= 3, 1);
                if (addr_q.size() == 0) fail("rd_addr_extra");
                else chk("rd_addr", rd_addr, addr_q.pop_front());
            end
            hs = out_valid && out_ready;
            if (hs) begin
                if (exp_q.size() == 0) fail("extra_word");
                else begin
                    mon_e = exp_q.pop_front();
                    chk("out_data", out_data, mon_e[31:0]);
                    chk("out_last", out_last, mon_e[32]);
                    if (out_last) exp_done_next = 1;
                end
                words++;
            end
            pend_pop = hs;
            stall = out_valid && !out_ready;
            stall_data = out_data;
        end
    end

    task automatic start_xfer(input logic [7:0] b, input logic [8:0] n);
        logic [7:0] a;
        for (int i = 0; i < int'(n); i++) begin
            a = b + 8'(i);
            addr_q.push_back(a);
            exp_q.push_back({i == int'(n) - 1, mem[a]});
        end
        @(negedge clk);
        base_addr = b;
        len = n;
        start = 1;
        @(posedge clk);
        #1 start = 0;
    endtask

    task automatic wait_done(input int budget);
        int c;
        c = 0;
        do begin
            @(negedge clk);
            c++;
        end while (!done && c < budget);
        chk("done_within_budget", done, 1);
    endtask

    task automatic settle(input string name, input int ws, input int ds, input int n);
        repeat (4) @(negedge clk);
        chk({name, "_words"}, words - ws, n);
        chk({name, "_done_pulses"}, done_cnt - ds, 1);
        chk({name, "_exp_left"}, exp_q.size(), 0);
        chk({name, "_addr_left"}, addr_q.size(), 0);
        chk({name, "_idle"}, {busy, out_valid}, 0);
    endtask

    task automatic chk_zero(input string name);
        chk({name, "_ctl"}, {busy, done, rd_en, out_valid, out_last}, 0);
        chk({name, "_rd_addr"}, rd_addr, 0);
        chk({name, "_out_data"}, out_data, 0);
    endtask

    initial begin
        #3 chk_zero("reset");
        @(negedge clk);
        rst_n = 1;

        w0 = words; d0 = done_cnt;
        start_xfer(8'h04, 9'd4);
        @(negedge clk);
        chk("start_busy", busy, 1);
        chk("start_rd_en", rd_en, 1);
        chk("start_rd_addr", rd_addr, 8'h04);
        chk("valid_k", out_valid, 0);
        @(negedge clk);
        chk("valid_k1", out_valid, 0);
        @(negedge clk);
        chk("valid_k2", out_valid, 1);
        chk("first_word", out_data, 32'hA4);
        wait_done(50);
        settle("basic", w0, d0, 4);

        rdy_mode = 2;
        w0 = words; d0 = done_cnt;
        start_xfer(8'h04, 9'd4);
        repeat (8) @(negedge clk);
        chk("hold_outstanding", outst, 3);
        chk("hold_rd_en", rd_en, 0);
        chk("hold_valid", out_valid, 1);
        chk("hold_data", out_data, 32'hA4);
        pi = 0;
        rdy_mode = 1;
        wait_done(80);
        settle("backpressure", w0, d0, 4);
        rdy_mode = 0;

        w0 = words; d0 = done_cnt;
        start_xfer(8'hFE, 9'd4);
        @(negedge clk);
        chk("wrap_first_addr", rd_addr, 8'hFE);
        wait_done(50);
        settle("wrap", w0, d0, 4);

        w0 = words; d0 = done_cnt;
        start_xfer(8'h05, 9'd0);
        @(negedge clk);
        chk("len0_done", {done, busy, rd_en, out_valid}, 4'b1000);
        @(negedge clk);
        chk("len0_done_drop", {done, rd_en, out_valid}, 3'b000);
        settle("len0", w0, d0, 0);

        w0 = words; d0 = done_cnt;
        start_xfer(8'h00, 9'd256);
        wait_done(400);
        settle("len256", w0, d0, 256);

        w0 = words; d0 = done_cnt;
        start_xfer(8'h20, 9'd6);
        repeat (3) @(negedge clk);
        base_addr = 8'h80;
        len = 9'd3;
        start = 1;
        @(negedge clk);
        start = 0;
        wait_done(50);
        settle("start_busy", w0, d0, 6);

        w0 = words;
        start_xfer(8'h10, 9'd8);
        for (int c = 0; c < 50 && words < w0 + 2; c++) @(negedge clk);
        chk("pre_reset_words", words - w0 >= 2, 1);
        #2 rst_n = 0;
        #1 chk_zero("midreset");
        exp_q.delete();
        addr_q.delete();
        repeat (2) @(negedge clk);
        rst_n = 1;
        w0 = words; d0 = done_cnt;
        start_xfer(8'h30, 9'd2);
        wait_done(50);
        settle("after_reset", w0, d0, 2);

        $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
        $finish;
    end
endmodule
